reservation_station: RTL and testbench

- Unified issue queue between dispatch and the functional units.
- Accepts renamed uOPs from dispatch and holds up to RS_ENTRIES of them.
- Tracks per-source physical-register readiness from writeback tag broadcasts.
- Each cycle, offers the oldest fully-ready entry to select/RegRead. Its fields map onto Sel_uOP (src1_index, src2_index, imm_val) plus opcode and dst tag.

---
 rtl/reservation_station.sv | 154 +++++++++++++++
 tb/tb_reservation_station.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Unified issue queue: holds renamed uOPs, wakes sources on writeback tag
// broadcasts and offers the oldest fully-ready entry to select/RegRead.
module reservation_station #(
  parameter  int unsigned RS_ENTRIES = 8,
  parameter  int unsigned NUM_PREGS  = 128,
  parameter  int unsigned OPC_W      = 6,
  localparam int unsigned PTAG_W     = $clog2(NUM_PREGS),
  localparam int unsigned OCC_W      = $clog2(RS_ENTRIES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OPC_W-1:0]  disp_opcode,
  input  logic [PTAG_W-1:0] disp_src1_tag,
  input  logic              disp_src1_rdy,
  input  logic [PTAG_W-1:0] disp_src2_tag,
  input  logic              disp_src2_rdy,
  input  logic [PTAG_W-1:0] disp_dst_tag,
  input  logic [31:0]       disp_imm,
  input  logic              wb_valid,
  input  logic [PTAG_W-1:0] wb_tag,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OPC_W-1:0]  iss_opcode,
  output logic [PTAG_W-1:0] iss_src1_tag,
  output logic [PTAG_W-1:0] iss_src2_tag,
  output logic [PTAG_W-1:0] iss_dst_tag,
  output logic [31:0]       iss_imm,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int unsigned IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

  logic [RS_ENTRIES-1:0] valid_q;
  logic [RS_ENTRIES-1:0] r1_q;
  logic [RS_ENTRIES-1:0] r2_q;
  logic [OPC_W-1:0]      opc_q [RS_ENTRIES];
  logic [PTAG_W-1:0]     s1_q  [RS_ENTRIES];
  logic [PTAG_W-1:0]     s2_q  [RS_ENTRIES];
  logic [PTAG_W-1:0]     dst_q [RS_ENTRIES];
  logic [31:0]           imm_q [RS_ENTRIES];
  // age_q[i][j] = 1: entry j is older than entry i
  logic [RS_ENTRIES-1:0] age_q [RS_ENTRIES];
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic [RS_ENTRIES-1:0] ready_vec;
  logic [IDX_W-1:0]      alloc_idx, sel_idx;
  logic                  alloc_found, sel_found;
  logic                  do_disp, do_iss;

  assign disp_ready = |(~valid_q);
  assign do_disp    = disp_valid && disp_ready;
  assign do_iss     = iss_valid && iss_ready;
  assign occupancy  = occ_q;

  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_idx   = IDX_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  // The age matrix is a strict order over valid entries, so at most one
  // ready entry has no ready older entry.
  always_comb begin
    ready_vec = valid_q & r1_q & r2_q;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      if (ready_vec[i] && ((age_q[i] & ready_vec) == '0) && !sel_found) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    iss_valid    = sel_found;
    iss_opcode   = '0;
    iss_src1_tag = '0;
    iss_src2_tag = '0;
    iss_dst_tag  = '0;
    iss_imm      = '0;
    if (sel_found) begin
      iss_opcode   = opc_q[sel_idx];
      iss_src1_tag = s1_q[sel_idx];
      iss_src2_tag = s2_q[sel_idx];
      iss_dst_tag  = dst_q[sel_idx];
      iss_imm      = imm_q[sel_idx];
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({do_disp, do_iss})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      occ_q   <= '0;
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
        age_q[i] <= '0;
        opc_q[i] <= '0;
        s1_q[i]  <= '0;
        s2_q[i]  <= '0;
        dst_q[i] <= '0;
        imm_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int unsigned i = 0; i < RS_ENTRIES; i++) age_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
        if (wb_valid && valid_q[i]) begin
          if (s1_q[i] == wb_tag) r1_q[i] <= 1'b1;
          if (s2_q[i] == wb_tag) r2_q[i] <= 1'b1;
        end
      end
      if (do_iss) valid_q[sel_idx] <= 1'b0;
      // The allocated slot is free in registered state, so it never
      // collides with the issued slot.
      if (do_disp) begin
        valid_q[alloc_idx] <= 1'b1;
        opc_q[alloc_idx]   <= disp_opcode;
        s1_q[alloc_idx]    <= disp_src1_tag;
        s2_q[alloc_idx]    <= disp_src2_tag;
        dst_q[alloc_idx]   <= disp_dst_tag;
        imm_q[alloc_idx]   <= disp_imm;
        r1_q[alloc_idx]    <= disp_src1_rdy | (wb_valid && (disp_src1_tag == wb_tag));
        r2_q[alloc_idx]    <= disp_src2_rdy | (wb_valid && (disp_src2_tag == wb_tag));
        age_q[alloc_idx]   <= valid_q;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
          if (IDX_W'(i) != alloc_idx) age_q[i][alloc_idx] <= 1'b0;
        end
      end
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station: dispatch, wakeup, age-ordered
// select, full/back-pressure, flush and asynchronous reset.
module tb_reservation_station;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [5:0]  disp_opcode;
  logic [6:0]  disp_src1_tag;
  logic        disp_src1_rdy;
  logic [6:0]  disp_src2_tag;
  logic        disp_src2_rdy;
  logic [6:0]  disp_dst_tag;
  logic [31:0] disp_imm;
  logic        wb_valid;
  logic [6:0]  wb_tag;
  logic        iss_valid;
  logic        iss_ready;
  logic [5:0]  iss_opcode;
  logic [6:0]  iss_src1_tag;
  logic [6:0]  iss_src2_tag;
  logic [6:0]  iss_dst_tag;
  logic [31:0] iss_imm;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  reservation_station #(.RS_ENTRIES(8), .NUM_PREGS(128), .OPC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_tag(disp_dst_tag), .disp_imm(disp_imm),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
    .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag),
    .iss_dst_tag(iss_dst_tag), .iss_imm(iss_imm), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [5:0] opc, input logic [6:0] s1, input logic r1,
                          input logic [6:0] s2, input logic r2, input logic [6:0] dst,
                          input logic [31:0] imm);
    disp_valid    = 1'b1;
    disp_opcode   = opc;
    disp_src1_tag = s1;
    disp_src1_rdy = r1;
    disp_src2_tag = s2;
    disp_src2_rdy = r2;
    disp_dst_tag  = dst;
    disp_imm      = imm;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got %0b exp 1", disp_ready); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %0b exp 0", iss_valid); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (iss_dst_tag !== 7'd0 || iss_imm !== 32'd0 || iss_opcode !== 6'd0) begin
      errors++; $display("FAIL reset_payload got dst=%0d imm=%0h opc=%0d exp 0", iss_dst_tag, iss_imm, iss_opcode); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    set_disp(6'd3, 7'd5, 1'b1, 7'd6, 1'b1, 7'd20, 32'h10);
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL basic_no_same_cycle got %0b exp 0", iss_valid); end
    cyc();
    disp_valid = 1'b0;
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL basic_iss_valid got %0b exp 1", iss_valid); end
    checks++; if (iss_dst_tag !== 7'd20 || iss_imm !== 32'h10) begin
      errors++; $display("FAIL basic_payload got dst=%0d imm=%0h exp dst=20 imm=10", iss_dst_tag, iss_imm); end
    checks++; if (iss_src1_tag !== 7'd5 || iss_src2_tag !== 7'd6 || iss_opcode !== 6'd3) begin
      errors++; $display("FAIL basic_srcs got s1=%0d s2=%0d opc=%0d exp 5 6 3", iss_src1_tag, iss_src2_tag, iss_opcode); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL basic_occ got %0d exp 1", occupancy); end
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    checks++; if (occupancy !== 4'd0 || iss_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain got occ=%0d iv=%0b exp 0 0", occupancy, iss_valid); end
  endtask

  task automatic test_age_wakeup();
    set_disp(6'd1, 7'd8, 1'b1, 7'd9, 1'b0, 7'd30, 32'hA);
    cyc();
    set_disp(6'd2, 7'd1, 1'b1, 7'd2, 1'b1, 7'd31, 32'hB);
    cyc();
    disp_valid = 1'b0;
    checks++; if (iss_valid !== 1'b1 || iss_dst_tag !== 7'd31) begin
      errors++; $display("FAIL wake_b_first got iv=%0b dst=%0d exp 1 31", iss_valid, iss_dst_tag); end
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL wake_occ2 got %0d exp 2", occupancy); end
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_a_blocked got %0b exp 0", iss_valid); end
    wb_valid = 1'b1;
    wb_tag   = 7'd9;
    #2;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_no_bypass got %0b exp 0", iss_valid); end
    cyc();
    wb_valid = 1'b0;
    checks++; if (iss_valid !== 1'b1 || iss_dst_tag !== 7'd30) begin
      errors++; $display("FAIL wake_a_offered got iv=%0b dst=%0d exp 1 30", iss_valid, iss_dst_tag); end
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL wake_drain got %0d exp 0", occupancy); end
  endtask

  task automatic test_disp_wakeup();
    set_disp(6'd4, 7'd12, 1'b0, 7'd13, 1'b1, 7'd40, 32'hC);
    wb_valid = 1'b1;
    wb_tag   = 7'd12;
    cyc();
    disp_valid = 1'b0;
    wb_valid   = 1'b0;
    checks++; if (iss_valid !== 1'b1 || iss_dst_tag !== 7'd40) begin
      errors++; $display("FAIL dispwake_c got iv=%0b dst=%0d exp 1 40", iss_valid, iss_dst_tag); end
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    set_disp(6'd5, 7'd14, 1'b0, 7'd14, 1'b0, 7'd41, 32'hD);
    cyc();
    disp_valid = 1'b0;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL dualwake_pending got %0b exp 0", iss_valid); end
    wb_valid = 1'b1;
    wb_tag   = 7'd14;
    cyc();
    wb_valid = 1'b0;
    checks++; if (iss_valid !== 1'b1 || iss_dst_tag !== 7'd41) begin
      errors++; $display("FAIL dualwake_both got iv=%0b dst=%0d exp 1 41", iss_valid, iss_dst_tag); end
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL dispwake_drain got %0d exp 0", occupancy); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      set_disp(6'd7, 7'd1, 1'b1, 7'd2, 1'b1, 7'(50 + i), 32'(i));
      cyc();
    end
    checks++; if (disp_ready !== 1'b0 || occupancy !== 4'd8) begin
      errors++; $display("FAIL full_state got rdy=%0b occ=%0d exp 0 8", disp_ready, occupancy); end
    checks++; if (iss_dst_tag !== 7'd50) begin errors++; $display("FAIL full_oldest got %0d exp 50", iss_dst_tag); end
    set_disp(6'd7, 7'd1, 1'b1, 7'd2, 1'b1, 7'd99, 32'h99);
    cyc();
    checks++; if (occupancy !== 4'd8 || iss_dst_tag !== 7'd50) begin
      errors++; $display("FAIL full_ignored got occ=%0d dst=%0d exp 8 50", occupancy, iss_dst_tag); end
    set_disp(6'd7, 7'd1, 1'b1, 7'd2, 1'b1, 7'd60, 32'h60);
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    checks++; if (occupancy !== 4'd7 || disp_ready !== 1'b1 || iss_dst_tag !== 7'd51) begin
      errors++; $display("FAIL full_freed got occ=%0d rdy=%0b dst=%0d exp 7 1 51", occupancy, disp_ready, iss_dst_tag); end
    cyc();
    disp_valid = 1'b0;
    checks++; if (occupancy !== 4'd8 || disp_ready !== 1'b0) begin
      errors++; $display("FAIL full_refill got occ=%0d rdy=%0b exp 8 0", occupancy, disp_ready); end
    iss_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (iss_dst_tag !== 7'((k < 7) ? 51 + k : 60)) begin
        errors++; $display("FAIL full_drain_%0d got %0d exp %0d", k, iss_dst_tag, (k < 7) ? 51 + k : 60); end
      cyc();
    end
    iss_ready = 1'b0;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL full_empty got %0d exp 0", occupancy); end
  endtask

  task automatic test_age_order();
    for (int i = 0; i < 3; i++) begin
      set_disp(6'd8, 7'd1, 1'b1, 7'd2, 1'b1, 7'(90 + i), 32'(i));
      cyc();
    end
    disp_valid = 1'b0;
    iss_ready  = 1'b1;
    cyc();
    cyc();
    iss_ready = 1'b0;
    checks++; if (occupancy !== 4'd1 || iss_dst_tag !== 7'd92) begin
      errors++; $display("FAIL age_setup got occ=%0d dst=%0d exp 1 92", occupancy, iss_dst_tag); end
    set_disp(6'd8, 7'd1, 1'b1, 7'd2, 1'b1, 7'd80, 32'h80);
    cyc();
    set_disp(6'd8, 7'd1, 1'b1, 7'd2, 1'b1, 7'd81, 32'h81);
    iss_ready = 1'b1;
    checks++; if (iss_dst_tag !== 7'd92) begin errors++; $display("FAIL age_first got %0d exp 92", iss_dst_tag); end
    cyc();
    disp_valid = 1'b0;
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL age_net0 got %0d exp 2", occupancy); end
    checks++; if (iss_dst_tag !== 7'd80) begin errors++; $display("FAIL age_second got %0d exp 80", iss_dst_tag); end
    cyc();
    checks++; if (iss_dst_tag !== 7'd81) begin errors++; $display("FAIL age_third got %0d exp 81", iss_dst_tag); end
    cyc();
    iss_ready = 1'b0;
    checks++; if (occupancy !== 4'd0 || iss_valid !== 1'b0) begin
      errors++; $display("FAIL age_empty got occ=%0d iv=%0b exp 0 0", occupancy, iss_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_disp(6'd9, 7'd1, 1'b1, 7'd2, 1'b1, 7'(100 + i), 32'(i));
      cyc();
    end
    checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d exp 5", occupancy); end
    flush     = 1'b1;
    iss_ready = 1'b1;
    wb_valid  = 1'b1;
    wb_tag    = 7'd3;
    cyc();
    flush      = 1'b0;
    iss_ready  = 1'b0;
    wb_valid   = 1'b0;
    disp_valid = 1'b0;
    checks++; if (occupancy !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      errors++; $display("FAIL flush_post got occ=%0d iv=%0b rdy=%0b exp 0 0 1", occupancy, iss_valid, disp_ready); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      set_disp(6'd10, 7'd1, 1'b1, 7'd2, 1'b1, 7'(110 + i), 32'hFF);
      cyc();
    end
    disp_valid = 1'b0;
    checks++; if (occupancy !== 4'd2 || iss_valid !== 1'b1) begin
      errors++; $display("FAIL arst_pre got occ=%0d iv=%0b exp 2 1", occupancy, iss_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (occupancy !== 4'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      errors++; $display("FAIL arst_ctrl got occ=%0d iv=%0b rdy=%0b exp 0 0 1", occupancy, iss_valid, disp_ready); end
    checks++; if (iss_imm !== 32'd0 || iss_dst_tag !== 7'd0) begin
      errors++; $display("FAIL arst_payload got imm=%0h dst=%0d exp 0 0", iss_imm, iss_dst_tag); end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0;
    disp_src1_tag = '0; disp_src1_rdy = 1'b0; disp_src2_tag = '0; disp_src2_rdy = 1'b0;
    disp_dst_tag = '0; disp_imm = '0; wb_valid = 1'b0; wb_tag = '0; iss_ready = 1'b0;
    test_reset();
    test_basic();
    test_age_wakeup();
    test_disp_wakeup();
    test_full();
    test_age_order();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
